instruction_fetch: RTL and testbench
====================================

# instruction_fetch

Fetch front end that drives the word-aligned byte address into the combinational instruction memory, captures each returned 18-bit instruction with its PC into a small FIFO, and presents it to decode through a valid/ready handshake. It owns the program counter, advancing by 4 per fetched word and accepting branch redirects from execute, which flush everything already fetched.

## Interface
- ADDR_W, 18, width of byte address / PC
- INSTR_W, 18, instruction width
- DEPTH, 2, fetch FIFO entries (power of two, ≥2)
- RESET_PC, 18'd0, PC loaded on reset (low 2 bits must be 0)

Ports:
- clk  in  1  single clock, all state updates on rising edge
- rst_n  in  1  synchronous, active-low reset
- fetch_en  in  1  1 = fetching allowed; 0 = stop issuing new fetches, the FIFO keeps draining
- imem_addr  out  ADDR_W  byte address to instruction memory; memory indexes by imem_addr[ADDR_W-1:2]
- imem_rd  in  INSTR_W  instruction returned combinationally for imem_addr in the same cycle
- instr_valid  out  1  FIFO head holds a valid instruction
- instr_ready  in  1  decode accepts the head this cycle
- instr_out  out  INSTR_W  head instruction
- pc_out  out  ADDR_W  byte address of head instruction
- redirect_valid  in  1  branch taken, load new PC
- redirect_pc  in  ADDR_W  branch target; bits [1:0] ignored (forced to 0)

## Operation
- Registered state: fetch_pc, FIFO storage {pc, instr}×DEPTH, rd_ptr, wr_ptr, count (0..DEPTH), state.
- imem_addr = fetch_pc at all times; fetch_pc[1:0] is always 00.
- FSM states: HOLD (fetch_en=0), FETCH (fetch_en=1). Transition on fetch_en, evaluated each cycle; a redirect does not change state.
- pop = instr_valid & instr_ready. push = (state==FETCH) & fetch_en & ~redirect_valid & (count<DEPTH | pop).
- On push: write {fetch_pc, imem_rd} at wr_ptr; fetch_pc <= fetch_pc + 4, modulo 2^ADDR_W (0x3FFFC wraps to 0x00000).
- On pop: rd_ptr advances. count += push - pop.
- Full with simultaneous pop: push allowed; count stays DEPTH.
- Empty: instr_valid=0; instr_out/pc_out show stale storage and are don't-care to decode.
- Redirect (highest priority): count<=0, rd_ptr<=wr_ptr, fetch_pc <= {redirect_pc[ADDR_W-1:2],2'b00}; no push that cycle. A pop in the redirect cycle is still a legal handshake. The flush is complete on the next edge.
- Redirect while in HOLD: PC and FIFO are updated the same way; fetching resumes from the new PC when fetch_en rises.
- Reset (rst_n=0 at edge, including mid-operation): fetch_pc=RESET_PC, count=0, pointers=0, storage=0, state=HOLD, instr_valid=0, instr_out=0, pc_out=0. Any in-flight entries are discarded.

## Timing
- Fetch latency: an instruction whose address is presented in cycle N is visible at the FIFO head (instr_valid=1) in cycle N+1 if the FIFO was empty.
- After reset releases with fetch_en=1: the first cycle transitions to FETCH (no push). The first push is in the next cycle, and valid goes high one cycle after that.
- Redirect asserted in cycle N: imem_addr = target in N+1, instr_valid=0 in N+1, first target instruction valid in N+2.
- Sustained throughput: 1 instr/cycle while instr_ready=1.
- instr_valid must not drop without a pop, except on redirect or reset. While instr_ready=0, instr_out/pc_out are held stable.
- No combinational path from instr_ready or redirect_valid to imem_addr.

## Test plan
- Reset then fetch_en=1 with ready=1, memory word k = 18'h100+k → pc_out/instr_out sequence 0/0x100, 4/0x101, 8/0x102… with no gaps after the first valid.
- ready=0 for 5 cycles after the first valid → count saturates at 2, imem_addr holds at 0x8, head stays 0/0x100. Releasing ready → 0x100, 0x101, 0x102 in order with no loss or duplicate.
- Redirect to 0x00015 while the FIFO is full → next imem_addr=0x00014, instr_valid=0 for one cycle, then pc_out=0x14 with word 5.
- Redirect and pop in the same cycle, and redirect while fetch_en=0 → the pop is consumed, the FIFO is empty next cycle, and fetching restarts at the target when enabled.
- Start from RESET_PC=0x3FFF8 → pc_out sequence 0x3FFF8, 0x3FFFC, 0x00000.
- Assert rst_n=0 mid-stream with 2 entries queued → next cycle instr_valid=0, imem_addr=RESET_PC, pc_out=0, instr_out=0.

Source files
------------

// File: rtl/instruction_fetch.sv
`default_nettype none
// ============================================================================
// Module      : instruction_fetch
// Description : PC generation, combinational imem access and a small fetch
//               FIFO with a valid/ready handshake and branch-redirect flush.
// Revision    : 1.0 - initial release
// ============================================================================
module instruction_fetch #(
    parameter int              ADDR_W   = 18,
    parameter int              INSTR_W  = 18,
    parameter int              DEPTH    = 2,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               fetch_en,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_rd,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [INSTR_W-1:0] instr_out,
    output logic [ADDR_W-1:0]  pc_out,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef enum logic [0:0] {
        ST_HOLD  = 1'b0,
        ST_FETCH = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  fetch_pc_q, fetch_pc_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [ADDR_W-1:0]  pc_mem_q    [DEPTH];
    logic [INSTR_W-1:0] instr_mem_q [DEPTH];

    logic w_push;
    logic w_pop;

    // ------------------------------------------------------------------
    // State machine
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_HOLD;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_HOLD:  if (fetch_en)  state_d = ST_FETCH;
            ST_FETCH: if (!fetch_en) state_d = ST_HOLD;
            default:  state_d = ST_HOLD;
        endcase
    end

    // ------------------------------------------------------------------
    // PC and FIFO bookkeeping; redirect overrides everything else
    // ------------------------------------------------------------------
    always_comb begin
        w_pop  = instr_valid & instr_ready;
        // A full FIFO still accepts a push when its head leaves this cycle.
        w_push = (state_q == ST_FETCH) & fetch_en & ~redirect_valid &
                 ((count_q < CNT_W'(DEPTH)) | w_pop);

        fetch_pc_d = fetch_pc_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;

        if (redirect_valid) begin
            fetch_pc_d = {redirect_pc[ADDR_W-1:2], 2'b00};
            rd_ptr_d   = wr_ptr_q;
            count_d    = '0;
        end else begin
            if (w_push) begin
                fetch_pc_d = fetch_pc_q + ADDR_W'(4);
                wr_ptr_d   = wr_ptr_q + PTR_W'(1);
            end
            if (w_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_pc_q <= RESET_PC;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
        end
    end

    // Storage is cleared on reset so the head reads as zero afterwards.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem_q[i]    <= '0;
                instr_mem_q[i] <= '0;
            end
        end else if (w_push) begin
            pc_mem_q[wr_ptr_q]    <= fetch_pc_q;
            instr_mem_q[wr_ptr_q] <= imem_rd;
        end
    end

    assign imem_addr   = fetch_pc_q;
    assign instr_valid = (count_q != '0);
    assign instr_out   = instr_mem_q[rd_ptr_q];
    assign pc_out      = pc_mem_q[rd_ptr_q];

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_instruction_fetch
// Description : Randomized and directed checks of instruction_fetch against a
//               queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instruction_fetch;

    localparam int DEPTH = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, fetch_en, instr_ready, redirect_valid;
    logic [17:0] redirect_pc;
    logic [17:0] imem_addr, imem_rd, instr_out, pc_out;
    logic        instr_valid;

    logic        rst2_n, en2, rdy2;
    logic [17:0] imem_addr2, imem_rd2, instr_out2, pc_out2;
    logic        instr_valid2;

    int total = 0;
    int bad   = 0;

    function automatic logic [17:0] mem_word(input logic [17:0] a);
        logic [15:0] idx;
        idx = a[17:2];
        return 18'h100 + {2'b00, idx};
    endfunction

    assign imem_rd  = mem_word(imem_addr);
    assign imem_rd2 = mem_word(imem_addr2);

    instruction_fetch #(.ADDR_W(18), .INSTR_W(18), .DEPTH(DEPTH), .RESET_PC(18'd0)) u_dut (
        .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en),
        .imem_addr(imem_addr), .imem_rd(imem_rd),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_out(instr_out), .pc_out(pc_out),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
    );

    instruction_fetch #(.ADDR_W(18), .INSTR_W(18), .DEPTH(DEPTH), .RESET_PC(18'h3FFF8)) u_wrap (
        .clk(clk), .rst_n(rst2_n), .fetch_en(en2),
        .imem_addr(imem_addr2), .imem_rd(imem_rd2),
        .instr_valid(instr_valid2), .instr_ready(rdy2),
        .instr_out(instr_out2), .pc_out(pc_out2),
        .redirect_valid(1'b0), .redirect_pc(18'd0)
    );

    // Reference model: next fetch address, queued {pc, instr} entries, and
    // whether fetching was already enabled at the previous edge.
    logic [17:0] m_pc;
    logic [17:0] q_pc[$];
    logic [17:0] q_in[$];
    logic        m_en_prev;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge();
        bit pop;
        if (!rst_n) begin
            q_pc.delete();
            q_in.delete();
            m_pc      = 18'd0;
            m_en_prev = 1'b0;
        end else begin
            pop = (q_pc.size() > 0) && instr_ready;
            if (pop) begin
                q_pc.delete(0);
                q_in.delete(0);
            end
            if (redirect_valid) begin
                q_pc.delete();
                q_in.delete();
                m_pc = redirect_pc & ~18'h3;
            end else if (m_en_prev && fetch_en && q_pc.size() < DEPTH) begin
                q_pc.push_back(m_pc);
                q_in.push_back(mem_word(m_pc));
                m_pc = m_pc + 18'd4;
            end
            m_en_prev = fetch_en;
        end
    endtask

    task automatic compare();
        chk("imem_addr", 32'(imem_addr), 32'(m_pc));
        chk("instr_valid", 32'(instr_valid), 32'(q_pc.size() > 0));
        if (q_pc.size() > 0) begin
            chk("pc_out", 32'(pc_out), 32'(q_pc[0]));
            chk("instr_out", 32'(instr_out), 32'(q_in[0]));
        end
    endtask

    task automatic step(input logic rn, input logic en, input logic rdy,
                        input logic rv, input logic [17:0] tgt);
        rst_n          = rn;
        fetch_en       = en;
        instr_ready    = rdy;
        redirect_valid = rv;
        redirect_pc    = tgt;
        model_edge();
        @(negedge clk);
        compare();
    endtask

    initial begin
        rst2_n = 1'b0;
        en2    = 1'b0;
        rdy2   = 1'b1;

        // Reset
        step(0, 0, 0, 0, 18'd0);
        step(0, 0, 0, 0, 18'd0);
        chk("rst_addr",  32'(imem_addr),   32'h0);
        chk("rst_valid", 32'(instr_valid), 32'h0);
        chk("rst_pc",    32'(pc_out),      32'h0);
        chk("rst_instr", 32'(instr_out),   32'h0);

        // Startup latency and backpressure
        step(1, 1, 0, 0, 18'd0);
        chk("start_novalid", 32'(instr_valid), 32'h0);
        step(1, 1, 0, 0, 18'd0);
        chk("first_valid", 32'(instr_valid), 32'h1);
        chk("first_instr", 32'(instr_out),   32'h100);
        repeat (5) step(1, 1, 0, 0, 18'd0);
        chk("hold_addr",  32'(imem_addr), 32'h8);
        chk("hold_pc",    32'(pc_out),    32'h0);
        chk("hold_instr", 32'(instr_out), 32'h100);
        step(1, 1, 1, 0, 18'd0);
        chk("drain1_instr", 32'(instr_out), 32'h101);
        step(1, 1, 1, 0, 18'd0);
        chk("drain2_pc",    32'(pc_out),    32'h8);
        chk("drain2_instr", 32'(instr_out), 32'h102);

        // Redirect with a full FIFO
        step(1, 1, 0, 0, 18'd0);
        step(1, 1, 0, 0, 18'd0);
        step(1, 1, 0, 1, 18'h00015);
        chk("redir_addr",  32'(imem_addr),   32'h14);
        chk("redir_valid", 32'(instr_valid), 32'h0);
        step(1, 1, 1, 0, 18'd0);
        chk("redir_pc",    32'(pc_out),    32'h14);
        chk("redir_instr", 32'(instr_out), 32'h105);

        // Redirect with simultaneous pop, then redirect while holding
        step(1, 1, 0, 0, 18'd0);
        step(1, 1, 1, 1, 18'h00040);
        chk("rpop_valid", 32'(instr_valid), 32'h0);
        repeat (3) step(1, 0, 1, 0, 18'd0);
        step(1, 0, 0, 1, 18'h00083);
        chk("hold_redir_addr", 32'(imem_addr), 32'h80);
        repeat (2) step(1, 0, 0, 0, 18'd0);
        step(1, 1, 1, 0, 18'd0);
        chk("resume_novalid", 32'(instr_valid), 32'h0);
        step(1, 1, 0, 0, 18'd0);
        chk("resume_pc",    32'(pc_out),    32'h80);
        chk("resume_instr", 32'(instr_out), 32'h120);

        // Reset mid-stream with entries queued
        step(1, 1, 0, 0, 18'd0);
        step(1, 1, 0, 0, 18'd0);
        step(0, 1, 0, 0, 18'd0);
        chk("mrst_valid", 32'(instr_valid), 32'h0);
        chk("mrst_addr",  32'(imem_addr),   32'h0);
        chk("mrst_pc",    32'(pc_out),      32'h0);
        chk("mrst_instr", 32'(instr_out),   32'h0);

        // Randomized traffic
        for (int i = 0; i < 800; i++) begin
            step($urandom_range(0, 99) != 0, $urandom_range(0, 9) != 0,
                 $urandom_range(0, 2) != 0, $urandom_range(0, 19) == 0,
                 18'($urandom));
        end

        // PC wrap-around from the top of the address space
        chk("wrap_rst_addr", 32'(imem_addr2), 32'h3FFF8);
        rst2_n = 1'b1;
        en2    = 1'b1;
        step(1, 1, 1, 0, 18'd0);
        step(1, 1, 1, 0, 18'd0);
        chk("wrap_valid0", 32'(instr_valid2), 32'h1);
        chk("wrap_pc0",    32'(pc_out2),      32'h3FFF8);
        step(1, 1, 1, 0, 18'd0);
        chk("wrap_pc1",    32'(pc_out2),      32'h3FFFC);
        step(1, 1, 1, 0, 18'd0);
        chk("wrap_pc2",    32'(pc_out2),      32'h00000);
        chk("wrap_instr2", 32'(instr_out2),   32'h100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
